radio_framer: RTL

RADIO_FRAMER -- requirements
Module: radio_framer

---
 rtl/radio_pkg.sv | 22 ++
 rtl/sample_fifo.sv | 78 +++++++
 rtl/radio_framer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/radio_pkg.sv
// -----------------------------------------------------------------------------
// radio_pkg
// Shared definitions for the radio framer: frame sync byte, header length and
// the framer FSM state encoding.
// -----------------------------------------------------------------------------
package radio_pkg;

    // First byte of every frame; not covered by the checksum.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Header bytes before the payload: sync, node id, length.
    localparam int HDR_LEN = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO buffering upstream sensor samples for the framer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push/push_data : write strobe and data (ignored when full)
//   pop/pop_data   : read strobe (ignored when empty); pop_data shows the head
//   full, empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        // NOTE: every signal written here gets a value first, so no path can
        // leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count
    // define which entries are valid, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/radio_framer.sv
// -----------------------------------------------------------------------------
// radio_framer
// Buffers 16-bit sensor samples and sends them to a byte-wide radio as frames:
//   A5, NODE_ID, LEN, payload (oldest sample first, MSB byte first), CHK
// CHK is the mod-256 sum of NODE_ID, LEN and the payload bytes.
//   enable        : allows new frames and sample pushes (a running frame finishes)
//   sample_valid/sample_data/sample_ready : upstream sample handshake
//   send/tx_data  : one-cycle byte start pulse and the byte, held until the
//                   radio finishes it
//   busy          : radio acknowledge (rises) and completion (falls)
//   frame_done    : pulse after the last byte completes
//   frame_err     : pulse when busy never rises after a send
// -----------------------------------------------------------------------------
module radio_framer
    import radio_pkg::*;
#(
    parameter logic [7:0] NODE_ID           = 8'h01,
    parameter int         SAMPLES_PER_FRAME = 4,
    parameter int         FIFO_DEPTH        = 8,
    parameter int         ACK_TIMEOUT       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    output logic        send,
    output logic [7:0]  tx_data,
    input  logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int         N        = SAMPLES_PER_FRAME;
    localparam int         LAST_IDX = HDR_LEN + 2 * N;   // index of the CHK byte
    localparam logic [7:0] LEN_BYTE = 8'(2 * N);
    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int         TW       = $clog2(ACK_TIMEOUT) + 1;

    // FIFO interface
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [15:0]   fifo_rd_data;
    logic [CW-1:0] fifo_count;

    // Framer state
    state_t      state_q, state_d;
    logic [2:0]  pop_cnt_q, pop_cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  chk_q, chk_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic        send_q, send_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] payload_q [8];
    logic [15:0] payload_d [8];

    // Next byte to issue
    logic        issue;
    logic [4:0]  issue_idx;
    logic [3:0]  pl_off;
    logic [15:0] pl_word;
    logic [7:0]  issue_byte;

    assign sample_ready = rst_n && enable && !fifo_full;
    assign fifo_push    = sample_valid && sample_ready;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (16)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (sample_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A byte is issued either when LOAD finishes (byte 0) or when WAIT_DONE
    // moves on to the following byte.
    always_comb begin
        issue_idx = (state_q == WAIT_DONE) ? idx_q + 5'd1 : 5'd0;
        pl_off    = 4'(issue_idx - 5'(HDR_LEN));
        pl_word   = payload_q[pl_off[3:1]];
        if (issue_idx == 5'd0) begin
            issue_byte = SYNC_BYTE;
        end else if (issue_idx == 5'd1) begin
            issue_byte = NODE_ID;
        end else if (issue_idx == 5'd2) begin
            issue_byte = LEN_BYTE;
        end else if (issue_idx == 5'(LAST_IDX)) begin
            issue_byte = chk_q;
        end else begin
            issue_byte = pl_off[0] ? pl_word[7:0] : pl_word[15:8];
        end
    end

    always_comb begin
        state_d      = state_q;
        pop_cnt_d    = pop_cnt_q;
        idx_d        = idx_q;
        chk_d        = chk_q;
        to_cnt_d     = to_cnt_q;
        tx_data_d    = tx_data_q;
        send_d       = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        payload_d    = payload_q;
        fifo_pop     = 1'b0;
        issue        = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && fifo_count >= CW'(N)) begin
                    state_d   = LOAD;
                    pop_cnt_d = 3'd0;
                end
            end
            LOAD: begin
                fifo_pop             = !fifo_empty;
                payload_d[pop_cnt_q] = fifo_rd_data;
                pop_cnt_d            = pop_cnt_q + 3'd1;
                if (pop_cnt_q == 3'(N - 1)) begin
                    issue = 1'b1;
                end
            end
            SEND: begin
                // The send cycle is the first cycle of the acknowledge wait,
                // so the error pulse lands ACK_TIMEOUT cycles after send.
                state_d  = WAIT_ACK;
                to_cnt_d = TW'(1);
            end
            WAIT_ACK: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q >= TW'(ACK_TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    if (idx_q == 5'(LAST_IDX)) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The checksum is accumulated as bytes go out; the sync byte restarts
        // it and the CHK byte itself is not added.
        if (issue) begin
            state_d   = SEND;
            send_d    = 1'b1;
            tx_data_d = issue_byte;
            idx_d     = issue_idx;
            if (issue_idx == 5'd0) begin
                chk_d = 8'h00;
            end else if (issue_idx != 5'(LAST_IDX)) begin
                chk_d = chk_q + issue_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pop_cnt_q    <= '0;
            idx_q        <= '0;
            chk_q        <= '0;
            to_cnt_q     <= '0;
            send_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pop_cnt_q    <= pop_cnt_d;
            idx_q        <= idx_d;
            chk_q        <= chk_d;
            to_cnt_q     <= to_cnt_d;
            send_q       <= send_d;
            tx_data_q    <= tx_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Payload contents are only read after LOAD has written them.
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    assign send       = send_q;
    assign tx_data    = tx_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
